// File: rtl/game_pkg.sv
// Shared types and constants for the fighter action scheduler: action states,
// keycode map for both players, default frame timings and a slot-match helper.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        STARTUP  = 3'd1,
        ACTIVE   = 3'd2,
        RECOVERY = 3'd3,
        HITSTUN  = 3'd4
    } action_state_t;

    localparam logic [7:0] KEY_P1_LEFT   = 8'h04;
    localparam logic [7:0] KEY_P1_RIGHT  = 8'h07;
    localparam logic [7:0] KEY_P1_BLOCK  = 8'h16;
    localparam logic [7:0] KEY_P1_JUMP   = 8'h1A;
    localparam logic [7:0] KEY_P1_ATTACK = 8'h09;

    localparam logic [7:0] KEY_P2_LEFT   = 8'h0D;
    localparam logic [7:0] KEY_P2_RIGHT  = 8'h0F;
    localparam logic [7:0] KEY_P2_BLOCK  = 8'h0E;
    localparam logic [7:0] KEY_P2_JUMP   = 8'h0C;
    localparam logic [7:0] KEY_P2_ATTACK = 8'h0B;

    localparam int unsigned DEF_STARTUP_FRAMES  = 3;
    localparam int unsigned DEF_ACTIVE_FRAMES   = 4;
    localparam int unsigned DEF_RECOVERY_FRAMES = 8;
    localparam int unsigned DEF_HITSTUN_FRAMES  = 10;
    localparam int unsigned DEF_X_STEP          = 2;

    // An empty slot (8'h00) must never register as a key press.
    function automatic logic key_present(input logic [7:0] s0, input logic [7:0] s1,
                                         input logic [7:0] s2, input logic [7:0] s3,
                                         input logic [7:0] code);
        return (code != 8'h00) &&
               ((s0 == code) || (s1 == code) || (s2 == code) || (s3 == code));
    endfunction

endpackage

// File: rtl/player_action_fsm.sv
// Per-player action sequencer: key edge detection, attack/hitstun timing and
// registered movement commands for one fighter.
module player_action_fsm
    import game_pkg::*;
#(
    parameter int unsigned STARTUP_FRAMES  = DEF_STARTUP_FRAMES,
    parameter int unsigned ACTIVE_FRAMES   = DEF_ACTIVE_FRAMES,
    parameter int unsigned RECOVERY_FRAMES = DEF_RECOVERY_FRAMES,
    parameter int unsigned HITSTUN_FRAMES  = DEF_HITSTUN_FRAMES,
    parameter int unsigned X_STEP          = DEF_X_STEP
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_block,
    input  logic       key_jump,
    input  logic       key_attack,
    input  logic       hit,
    output logic [9:0] x_motion,
    output logic       jump,
    output logic       attack_act,
    output logic       blocking,
    output logic [2:0] state
);

    localparam logic [3:0] LD_STARTUP  = 4'(STARTUP_FRAMES - 1);
    localparam logic [3:0] LD_ACTIVE   = 4'(ACTIVE_FRAMES - 1);
    localparam logic [3:0] LD_RECOVERY = 4'(RECOVERY_FRAMES - 1);
    localparam logic [3:0] LD_HITSTUN  = 4'(HITSTUN_FRAMES - 1);
    localparam logic [9:0] STEP_POS    = 10'(X_STEP);
    localparam logic [9:0] STEP_NEG    = ~STEP_POS + 10'd1;

    action_state_t state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          prev_jump_q, prev_jump_d;
    logic          prev_attack_q, prev_attack_d;
    logic [9:0]    x_motion_q, x_motion_d;
    logic          jump_q, jump_d;
    logic          attack_act_q, attack_act_d;
    logic          blocking_q, blocking_d;
    logic          atk_edge, jmp_edge;

    always_comb begin
        atk_edge      = key_attack & ~prev_attack_q;
        jmp_edge      = key_jump & ~prev_jump_q;
        state_d       = state_q;
        cnt_d         = cnt_q;
        prev_jump_d   = key_jump;
        prev_attack_d = key_attack;
        x_motion_d    = '0;
        jump_d        = 1'b0;
        blocking_d    = 1'b0;

        case (state_q)
            // Priority chain: only the highest-ranked IDLE command takes effect.
            IDLE: begin
                if (hit && !key_block) begin
                    state_d = HITSTUN;
                    cnt_d   = LD_HITSTUN;
                end else if (atk_edge) begin
                    state_d = STARTUP;
                    cnt_d   = LD_STARTUP;
                end else if (key_block) begin
                    blocking_d = 1'b1;
                end else if (jmp_edge) begin
                    jump_d = 1'b1;
                end else if (key_left ^ key_right) begin
                    x_motion_d = key_left ? STEP_NEG : STEP_POS;
                end
            end
            STARTUP, ACTIVE, RECOVERY: begin
                if (hit) begin
                    state_d = HITSTUN;
                    cnt_d   = LD_HITSTUN;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (state_q == STARTUP) begin
                    state_d = ACTIVE;
                    cnt_d   = LD_ACTIVE;
                end else if (state_q == ACTIVE) begin
                    state_d = RECOVERY;
                    cnt_d   = LD_RECOVERY;
                end else begin
                    state_d = IDLE;
                end
            end
            HITSTUN: begin
                if (hit) begin
                    cnt_d = LD_HITSTUN;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        attack_act_d = (state_d == ACTIVE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            prev_jump_q   <= 1'b0;
            prev_attack_q <= 1'b0;
            x_motion_q    <= '0;
            jump_q        <= 1'b0;
            attack_act_q  <= 1'b0;
            blocking_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            prev_jump_q   <= prev_jump_d;
            prev_attack_q <= prev_attack_d;
            x_motion_q    <= x_motion_d;
            jump_q        <= jump_d;
            attack_act_q  <= attack_act_d;
            blocking_q    <= blocking_d;
        end
    end

    assign x_motion   = x_motion_q;
    assign jump       = jump_q;
    assign attack_act = attack_act_q;
    assign blocking   = blocking_q;
    assign state      = state_q;

endmodule

// File: rtl/player_action_sched.sv
// Two-fighter action scheduler top: decodes the four keycode slots into
// per-player key flags and drives one action sequencer per player.
module player_action_sched
    import game_pkg::*;
#(
    parameter int unsigned STARTUP_FRAMES  = DEF_STARTUP_FRAMES,
    parameter int unsigned ACTIVE_FRAMES   = DEF_ACTIVE_FRAMES,
    parameter int unsigned RECOVERY_FRAMES = DEF_RECOVERY_FRAMES,
    parameter int unsigned HITSTUN_FRAMES  = DEF_HITSTUN_FRAMES,
    parameter int unsigned X_STEP          = DEF_X_STEP
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode_0,
    input  logic [7:0] keycode_1,
    input  logic [7:0] keycode_2,
    input  logic [7:0] keycode_3,
    input  logic       hit_p1,
    input  logic       hit_p2,
    output logic [9:0] p1_x_motion,
    output logic       p1_jump,
    output logic       p1_attack_act,
    output logic       p1_blocking,
    output logic [2:0] p1_state,
    output logic [9:0] p2_x_motion,
    output logic       p2_jump,
    output logic       p2_attack_act,
    output logic       p2_blocking,
    output logic [2:0] p2_state
);

    logic p1_left, p1_right, p1_block, p1_jmp, p1_atk;
    logic p2_left, p2_right, p2_block, p2_jmp, p2_atk;

    assign p1_left  = key_present(keycode_0, keycode_1, keycode_2, keycode_3, KEY_P1_LEFT);
    assign p1_right = key_present(keycode_0, keycode_1, keycode_2, keycode_3, KEY_P1_RIGHT);
    assign p1_block = key_present(keycode_0, keycode_1, keycode_2, keycode_3, KEY_P1_BLOCK);
    assign p1_jmp   = key_present(keycode_0, keycode_1, keycode_2, keycode_3, KEY_P1_JUMP);
    assign p1_atk   = key_present(keycode_0, keycode_1, keycode_2, keycode_3, KEY_P1_ATTACK);

    assign p2_left  = key_present(keycode_0, keycode_1, keycode_2, keycode_3, KEY_P2_LEFT);
    assign p2_right = key_present(keycode_0, keycode_1, keycode_2, keycode_3, KEY_P2_RIGHT);
    assign p2_block = key_present(keycode_0, keycode_1, keycode_2, keycode_3, KEY_P2_BLOCK);
    assign p2_jmp   = key_present(keycode_0, keycode_1, keycode_2, keycode_3, KEY_P2_JUMP);
    assign p2_atk   = key_present(keycode_0, keycode_1, keycode_2, keycode_3, KEY_P2_ATTACK);

    player_action_fsm #(
        .STARTUP_FRAMES (STARTUP_FRAMES),
        .ACTIVE_FRAMES  (ACTIVE_FRAMES),
        .RECOVERY_FRAMES(RECOVERY_FRAMES),
        .HITSTUN_FRAMES (HITSTUN_FRAMES),
        .X_STEP         (X_STEP)
    ) u_p1 (
        .clk       (frame_clk),
        .reset     (Reset),
        .key_left  (p1_left),
        .key_right (p1_right),
        .key_block (p1_block),
        .key_jump  (p1_jmp),
        .key_attack(p1_atk),
        .hit       (hit_p1),
        .x_motion  (p1_x_motion),
        .jump      (p1_jump),
        .attack_act(p1_attack_act),
        .blocking  (p1_blocking),
        .state     (p1_state)
    );

    player_action_fsm #(
        .STARTUP_FRAMES (STARTUP_FRAMES),
        .ACTIVE_FRAMES  (ACTIVE_FRAMES),
        .RECOVERY_FRAMES(RECOVERY_FRAMES),
        .HITSTUN_FRAMES (HITSTUN_FRAMES),
        .X_STEP         (X_STEP)
    ) u_p2 (
        .clk       (frame_clk),
        .reset     (Reset),
        .key_left  (p2_left),
        .key_right (p2_right),
        .key_block (p2_block),
        .key_jump  (p2_jmp),
        .key_attack(p2_atk),
        .hit       (hit_p2),
        .x_motion  (p2_x_motion),
        .jump      (p2_jump),
        .attack_act(p2_attack_act),
        .blocking  (p2_blocking),
        .state     (p2_state)
    );

endmodule

// File: tb/tb_player_action_sched.sv
// Scoreboard bench for player_action_sched: each driven frame pushes the
// hand-derived expected outputs; a monitor pops and compares after every edge.
module tb_player_action_sched;
    import game_pkg::*;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic [7:0] keycode_0, keycode_1, keycode_2, keycode_3;
    logic       hit_p1, hit_p2;
    logic [9:0] p1_x_motion, p2_x_motion;
    logic       p1_jump, p1_attack_act, p1_blocking;
    logic       p2_jump, p2_attack_act, p2_blocking;
    logic [2:0] p1_state, p2_state;

    player_action_sched dut (
        .frame_clk    (frame_clk),
        .Reset        (Reset),
        .keycode_0    (keycode_0),
        .keycode_1    (keycode_1),
        .keycode_2    (keycode_2),
        .keycode_3    (keycode_3),
        .hit_p1       (hit_p1),
        .hit_p2       (hit_p2),
        .p1_x_motion  (p1_x_motion),
        .p1_jump      (p1_jump),
        .p1_attack_act(p1_attack_act),
        .p1_blocking  (p1_blocking),
        .p1_state     (p1_state),
        .p2_x_motion  (p2_x_motion),
        .p2_jump      (p2_jump),
        .p2_attack_act(p2_attack_act),
        .p2_blocking  (p2_blocking),
        .p2_state     (p2_state)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct packed {
        logic [2:0] st;
        logic [9:0] x;
        logic       j;
        logic       a;
        logic       b;
    } pexp_t;

    typedef struct {
        pexp_t p1;
        pexp_t p2;
        string tag;
    } exp_t;

    exp_t        sb[$];
    int unsigned checks = 0;
    int unsigned passed = 0;
    bit          stim_done = 1'b0;

    localparam logic [9:0] XL = 10'h3FE;  // -2
    localparam logic [9:0] XR = 10'h002;  // +2
    localparam logic [9:0] X0 = 10'h000;

    function automatic pexp_t pe(input logic [2:0] s, input logic [9:0] x, input logic j,
                                 input logic b);
        pexp_t r;
        r.st = s;
        r.x  = x;
        r.j  = j;
        r.a  = (s == 3'd2);
        r.b  = b;
        return r;
    endfunction

    // State after the i-th edge counted from the attack-press edge (i = 1).
    function automatic logic [2:0] atk_st(input int i);
        if (i <= 3)  return 3'd1;
        if (i <= 7)  return 3'd2;
        if (i <= 15) return 3'd3;
        return 3'd0;
    endfunction

    task automatic frame(input logic rst, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d, input logic h1,
                         input logic h2, input pexp_t e1, input pexp_t e2, input string tag);
        exp_t e;
        @(negedge frame_clk);
        Reset     = rst;
        keycode_0 = a;
        keycode_1 = b;
        keycode_2 = c;
        keycode_3 = d;
        hit_p1    = h1;
        hit_p2    = h2;
        e.p1  = e1;
        e.p2  = e2;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Monitor
    initial begin
        exp_t  e;
        pexp_t act;
        forever begin
            @(posedge frame_clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                act = {p1_state, p1_x_motion, p1_jump, p1_attack_act, p1_blocking};
                checks++;
                if (act === e.p1) passed++;
                else $display("FAIL %s p1 got st=%0d x=%0d j=%b a=%b b=%b want st=%0d x=%0d j=%b a=%b b=%b",
                              e.tag, act.st, $signed(act.x), act.j, act.a, act.b,
                              e.p1.st, $signed(e.p1.x), e.p1.j, e.p1.a, e.p1.b);
                act = {p2_state, p2_x_motion, p2_jump, p2_attack_act, p2_blocking};
                checks++;
                if (act === e.p2) passed++;
                else $display("FAIL %s p2 got st=%0d x=%0d j=%b a=%b b=%b want st=%0d x=%0d j=%b a=%b b=%b",
                              e.tag, act.st, $signed(act.x), act.j, act.a, act.b,
                              e.p2.st, $signed(e.p2.x), e.p2.j, e.p2.a, e.p2.b);
            end
        end
    end

    // Stimulus
    initial begin
        pexp_t i0;
        i0 = pe(3'd0, X0, 1'b0, 1'b0);
        Reset = 1'b1;
        keycode_0 = '0; keycode_1 = '0; keycode_2 = '0; keycode_3 = '0;
        hit_p1 = 1'b0; hit_p2 = 1'b0;

        // Reset and horizontal motion
        frame(1, 8'h04, 8'h0F, 8'h00, 8'h00, 0, 0, i0, i0, "reset_with_keys");
        frame(0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, i0, i0, "idle");
        repeat (3) frame(0, 8'h00, 8'h00, 8'h04, 8'h00, 0, 0, pe(3'd0, XL, 0, 0), i0, "p1_left");
        frame(0, 8'h00, 8'h07, 8'h00, 8'h00, 0, 0, pe(3'd0, XR, 0, 0), i0, "p1_right");
        repeat (2) frame(0, 8'h04, 8'h07, 8'h00, 8'h00, 0, 0, i0, i0, "p1_both");
        frame(0, 8'h04, 8'h00, 8'h00, 8'h0F, 0, 0, pe(3'd0, XL, 0, 0), pe(3'd0, XR, 0, 0), "split_move");
        frame(0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, i0, i0, "release1");

        // Attack held 20 frames (first frame with move key), P2 taps attack alongside
        frame(0, 8'h09, 8'h07, 8'h0B, 8'h00, 0, 0, pe(3'd1, X0, 0, 0), pe(3'd1, X0, 0, 0), "atk_move");
        for (int i = 2; i <= 20; i++)
            frame(0, 8'h09, 8'h00, 8'h00, 8'h00, 0, 0, pe(atk_st(i), X0, 0, 0),
                  pe(atk_st(i), X0, 0, 0), "atk_hold");
        frame(0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, i0, i0, "release2");

        // Jump edge behaviour
        frame(0, 8'h1A, 8'h00, 8'h00, 8'h00, 0, 0, pe(3'd0, X0, 1, 0), i0, "jump");
        repeat (4) frame(0, 8'h1A, 8'h00, 8'h00, 8'h00, 0, 0, i0, i0, "jump_hold");
        frame(0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, i0, i0, "release3");
        frame(0, 8'h00, 8'h1A, 8'h0C, 8'h00, 0, 0, pe(3'd0, X0, 1, 0), pe(3'd0, X0, 1, 0), "jump_again");
        frame(0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, i0, i0, "release4");
        frame(0, 8'h1A, 8'h16, 8'h00, 8'h00, 0, 0, pe(3'd0, X0, 0, 1), i0, "jump_blocked");
        frame(0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, i0, i0, "release5");

        // Hit during ACTIVE, re-hit during stun; P2 hit while idle
        for (int e = 1; e <= 22; e++) begin
            logic [2:0] s1, s2;
            s1 = (e <= 3) ? 3'd1 : (e <= 5) ? 3'd2 : (e <= 20) ? 3'd4 : 3'd0;
            s2 = (e >= 6 && e <= 15) ? 3'd4 : 3'd0;
            frame(0, (e == 1) ? 8'h09 : 8'h00, 8'h00, 8'h00, 8'h00,
                  (e == 6 || e == 11), (e == 6), pe(s1, X0, 0, 0), pe(s2, X0, 0, 0), "hitstun");
        end

        // Blocked hit
        frame(0, 8'h16, 8'h00, 8'h00, 8'h00, 0, 0, pe(3'd0, X0, 0, 1), i0, "block");
        frame(0, 8'h16, 8'h00, 8'h00, 8'h00, 1, 0, pe(3'd0, X0, 0, 1), i0, "block_hit");
        frame(0, 8'h16, 8'h00, 8'h00, 8'h00, 0, 0, pe(3'd0, X0, 0, 1), i0, "block_after");
        frame(0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, i0, i0, "release6");

        // Reset mid-RECOVERY clears everything, including the attack prev-key flag
        for (int e = 1; e <= 9; e++)
            frame(0, 8'h09, 8'h00, 8'h00, 8'h00, 0, 0, pe(atk_st(e), X0, 0, 0), i0, "pre_reset");
        frame(1, 8'h09, 8'h04, 8'h0B, 8'h00, 0, 0, i0, i0, "reset_mid_recovery");
        frame(0, 8'h09, 8'h00, 8'h00, 8'h00, 0, 0, pe(3'd1, X0, 0, 0), i0, "post_reset_edge");
        frame(1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, i0, i0, "final_reset");

        repeat (2) @(posedge frame_clk);
        #2;
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL drain got %0d pending want 0", sb.size());
        end
        stim_done = 1'b1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        if (!stim_done) begin
            $display("FAIL timeout got running want finished");
            $fatal(1, "timeout");
        end
    end

endmodule
